alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Sequencer/arbiter that shares the single combinational ALU between two requesters (port 0: pipeline execute stage, port 1: in-memory compute unit). Accepts one operation at a time via valid/ready, round-robin arbitrates, holds operands stable on the ALU for the op's latency, and returns the registered result with a response handshake. Sits between the requesters and the ALU instance in the execute stage.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 5, alu_control width
- MULDIV_LAT, 4, EXEC cycles for MUL/MULI/DIV/DIVI (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request pending on port N
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  OP_W  ALU opcode
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands
- alu_control  out  OP_W  to ALU
- alu_a, alu_b  out  DATA_W  to ALU
- alu_result  in  DATA_W  from ALU
- alu_zero, alu_less_than  in  1  from ALU
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  port that issued the op
- rsp_result  out  DATA_W  captured result
- rsp_zero, rsp_lt  out  1  captured flags

## Operation
- States: IDLE, EXEC, RESP. Reset → IDLE.
- IDLE: grant = sole valid port; both valid → port ≠ last_grant. reqN_ready = (IDLE && grant==N), combinational. On accept: latch op/a/b/id into internal regs, last_grant←N, cnt←lat−1, → EXEC. No valid → stay.
- lat = MULDIV_LAT for MUL/MULI/DIV/DIVI, else 1.
- EXEC: alu_control/alu_a/alu_b driven from latched regs only. cnt≠0 → cnt−1. cnt==0 → capture alu_result/alu_zero/alu_less_than into rsp regs, → RESP.
- RESP: rsp_valid=1, rsp regs stable. rsp_valid && rsp_ready → IDLE. No new request accepted in RESP.
- Outside EXEC: alu_control = 0 (NULL opcode), alu_a = alu_b = 0.
- Requester rule: valid and operands held until ready; controller never samples unaccepted data.
- Div-by-zero, overflow: passed through from ALU unchanged; no controller handling.
- Reset values: state IDLE, last_grant=1 (port 0 wins first tie), cnt=0, all rsp regs 0, rsp_valid=0, reqN_ready=0, alu_* = 0.
- Reset asserted mid-EXEC/RESP: op discarded, no response ever issued for it.

## Timing
- Accept at edge T (ready=1 in cycle T). EXEC cycles T+1..T+lat. rsp_valid high from cycle T+lat+1.
- Single-cycle op: rsp_valid in cycle T+2; MUL with MULDIV_LAT=4: cycle T+5.
- Response accepted at edge R → IDLE in R+1; earliest next accept in R+1. Minimum throughput: one op per lat+2 cycles with rsp_ready tied high.
- rsp_ready held low: RESP indefinitely, outputs frozen, both reqN_ready=0.

## Configuration
- ALU_SHARE_MULTICYCLE_EN defined: MUL/MULI/DIV/DIVI use MULDIV_LAT EXEC cycles as above.
- Undefined: every op lat=1; cnt register and opcode decode removed; MULDIV_LAT ignored.

## Structure
- Shared package alu_pkg: opcode constants (ADD…SLT incl. MUL/MULI/DIV/DIVI), OP_W, DATA_W, state enum typedef {IDLE, EXEC, RESP}.
- Sub-module rr_arbiter2: inputs req[1:0], last_grant; output grant index and any_req. Rest in top.

## Test plan
- Reset: rst_n low mid-EXEC → rsp_valid=0, state IDLE, alu_control=0, no response after release.
- Port 0 ADD a=5,b=7 accepted at T, rsp_ready=1 → rsp_valid at T+2, rsp_result=12, rsp_id=0, rsp_zero=0.
- Both valid every cycle, rsp_ready=1 → grants alternate 0,1,0,1; port 0 first after reset.
- MUL a=−3,b=4 with macro defined, MULDIV_LAT=4 → alu inputs stable 4 cycles, rsp_result=0xFFFFFFF4 at T+5; macro undefined → at T+2.
- rsp_ready low 10 cycles after SUB 9−9 → rsp_valid held, rsp_result=0, rsp_zero=1 stable, req1_valid=1 sees ready=0 throughout; accepted one cycle after rsp handshake.
- SLT a=−1,b=1 → rsp_result=1, rsp_lt=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, widths, sequencer state type and opcode helpers
//   Used by alu_share_ctrl and its testbench; no ports.
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int OP_W   = 5;
  localparam logic [OP_W-1:0] OP_NULL = 5'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd2;
  localparam logic [OP_W-1:0] OP_AND  = 5'd3;
  localparam logic [OP_W-1:0] OP_OR   = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 5'd5;
  localparam logic [OP_W-1:0] OP_SLL  = 5'd6;
  localparam logic [OP_W-1:0] OP_SRL  = 5'd7;
  localparam logic [OP_W-1:0] OP_SRA  = 5'd8;
  localparam logic [OP_W-1:0] OP_SLT  = 5'd9;
  localparam logic [OP_W-1:0] OP_SLTU = 5'd10;
  localparam logic [OP_W-1:0] OP_ADDI = 5'd11;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd12;
  localparam logic [OP_W-1:0] OP_MULI = 5'd13;
  localparam logic [OP_W-1:0] OP_DIV  = 5'd14;
  localparam logic [OP_W-1:0] OP_DIVI = 5'd15;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return op inside {OP_MUL, OP_MULI, OP_DIV, OP_DIVI};
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant selection
//   i_req[1:0]    pending requests (bit N = port N)
//   i_last_grant  port granted most recently
//   o_grant       index of the port to serve (meaningful when o_any_req)
//   o_any_req     at least one request pending
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_any_req
);
  assign o_any_req = |i_req;
  // a tie goes to the port that did not win last time; otherwise the sole requester
  assign o_grant = &i_req ? ~i_last_grant : i_req[1];
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer sharing one combinational ALU between two requesters
//   Build option ALU_SHARE_MULTICYCLE_EN: MUL/MULI/DIV/DIVI hold the ALU for MULDIV_LAT cycles;
//   without it every op executes in a single cycle and MULDIV_LAT is ignored.
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b    request port 0 (execute stage) and port 1 (in-memory compute)
//   alu_control/alu_a/alu_b    operands to the shared ALU (zero when not executing)
//   alu_result/zero/less_than  ALU outputs, captured at the end of execution
//   rsp_valid/ready            response handshake carrying rsp_id, rsp_result, rsp_zero, rsp_lt
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 5,
  parameter int MULDIV_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [OP_W-1:0]   alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_less_than,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_lt
);
  state_t            r_state;
  logic              r_last;
  logic              r_id;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_lt;
  logic              w_grant;
  logic              w_any;
  logic              w_accept;
  logic              w_exec;
  logic              w_done;
  logic [OP_W-1:0]   w_op;

  rr_arbiter2 u_arb (
    .i_req        ({req1_valid, req0_valid}),
    .i_last_grant (r_last),
    .o_grant      (w_grant),
    .o_any_req    (w_any)
  );

  // ready is gated by rst_n so it reads 0 while reset is held, not just after it
  assign w_accept   = rst_n && r_state == IDLE && w_any;
  assign req0_ready = w_accept && !w_grant;
  assign req1_ready = w_accept && w_grant;
  assign w_op       = w_grant ? req1_op : req0_op;
  assign w_exec     = r_state == EXEC;
  assign alu_control = w_exec ? r_op : '0;
  assign alu_a      = w_exec ? r_a : '0;
  assign alu_b      = w_exec ? r_b : '0;
  assign rsp_valid  = r_state == RESP;
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_lt     = r_lt;

`ifdef ALU_SHARE_MULTICYCLE_EN
  localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  logic [CW-1:0] r_cnt;
  // cnt holds the EXEC cycles still to go after the current one
  assign w_done = r_cnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_accept)
      r_cnt <= is_muldiv(w_op) ? CW'(MULDIV_LAT - 1) : '0;
    else if (w_exec && !w_done)
      r_cnt <= r_cnt - CW'(1);
  end
`else
  assign w_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_lt     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_op    <= w_op;
          r_a     <= w_grant ? req1_a : req0_a;
          r_b     <= w_grant ? req1_b : req0_b;
          r_id    <= w_grant;
          r_last  <= w_grant;
          r_state <= EXEC;
        end
        EXEC: if (w_done) begin
          r_result <= alu_result;
          r_zero   <= alu_zero;
          r_lt     <= alu_less_than;
          r_state  <= RESP;
        end
        RESP: if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: randomized scoreboard bench for alu_share_ctrl with a stand-in ALU
module tb_alu_share_ctrl;
  import alu_pkg::*;
  localparam int LAT = 4;
`ifdef ALU_SHARE_MULTICYCLE_EN
  localparam int MUL_RSP = LAT + 1;
`else
  localparam int MUL_RSP = 2;
`endif

  typedef struct {logic [4:0] op; logic [31:0] a; logic [31:0] b;} req_t;
  typedef struct {logic id; logic [4:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] res; logic z; logic lt; int t; int due;} exp_t;

  logic clk = 0;
  logic rst_n = 0;
  logic [1:0] v = '0;
  logic [4:0] op [2];
  logic [31:0] a [2];
  logic [31:0] b [2];
  logic rdy0, rdy1, rrdy;
  logic [4:0] alu_control;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic alu_zero, alu_lt, rsp_valid, rsp_id, rsp_zero, rsp_lt;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  req_t q0[$];
  req_t q1[$];
  exp_t sb[$];
  logic ids[$];
  logic busy = 0;
  logic last = 1;
  logic in_rsp = 0;
  exp_t cur;
  int got_lat;
  logic [31:0] got_res;
  logic got_id, got_z, got_lt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_ctrl #(.DATA_W(32), .OP_W(5), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0]), .req0_ready(rdy0), .req0_op(op[0]), .req0_a(a[0]), .req0_b(b[0]),
    .req1_valid(v[1]), .req1_ready(rdy1), .req1_op(op[1]), .req1_a(a[1]), .req1_b(b[1]),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_less_than(alu_lt),
    .rsp_valid(rsp_valid), .rsp_ready(rrdy), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_lt(rsp_lt)
  );

  function automatic logic [31:0] ref_alu(logic [4:0] o, logic [31:0] x, logic [31:0] y);
    case (o)
      OP_ADD, OP_ADDI: return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_SLL:  return x << y[4:0];
      OP_SRL:  return x >> y[4:0];
      OP_SRA:  return $signed(x) >>> y[4:0];
      OP_SLT:  return {31'b0, $signed(x) < $signed(y)};
      OP_SLTU: return {31'b0, x < y};
      OP_MUL, OP_MULI: return x * y;
      OP_DIV, OP_DIVI: begin
        if (y == 0) return '1;
        if (x == 32'h8000_0000 && y == '1) return x;
        return $signed(x) / $signed(y);
      end
      default: return '0;
    endcase
  endfunction

  function automatic int ref_lat(logic [4:0] o);
`ifdef ALU_SHARE_MULTICYCLE_EN
    return (o inside {OP_MUL, OP_MULI, OP_DIV, OP_DIVI}) ? LAT : 1;
`else
    return (o == OP_NULL) ? 1 : 1;
`endif
  endfunction

  // Stand-in ALU: yields a corrupted result until its inputs have been steady for the op's latency
  logic [4:0] p_op = '0;
  logic [31:0] p_a = '0;
  logic [31:0] p_b = '0;
  int stab = 0;
  always @(posedge clk) begin
    stab <= ({alu_control, alu_a, alu_b} == {p_op, p_a, p_b}) ? stab + 1 : 0;
    p_op <= alu_control;
    p_a <= alu_a;
    p_b <= alu_b;
  end
  always_comb begin
    alu_result = ref_alu(alu_control, alu_a, alu_b);
    if (stab + 1 < ref_lat(alu_control)) alu_result = ~alu_result;
    alu_zero = alu_result == '0;
    alu_lt = $signed(alu_a) < $signed(alu_b);
  end

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Requester driver: holds each request until it is seen accepted, then loads the next
  initial begin
    logic [1:0] acc;
    req_t r;
    forever begin
      @(negedge clk);
      acc = {v[1] && rdy1, v[0] && rdy0};
      @(posedge clk);
      #1;
      if (!rst_n) v = '0;
      else begin
        if (acc[0]) v[0] = 1'b0;
        if (acc[1]) v[1] = 1'b0;
        if (!v[0] && q0.size() > 0) begin
          r = q0.pop_front();
          op[0] = r.op; a[0] = r.a; b[0] = r.b; v[0] = 1'b1;
        end
        if (!v[1] && q1.size() > 0) begin
          r = q1.pop_front();
          op[1] = r.op; a[1] = r.a; b[1] = r.b; v[1] = 1'b1;
        end
      end
    end
  end

  // Monitor: arbitration/ready model, scoreboard push on accept, pop and compare on response
  always @(negedge clk) begin
    logic g;
    logic [1:0] er;
    exp_t e;
    if (!rst_n) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu", {alu_control, alu_a, alu_b}, 0);
      chk("rst_ready", {rdy1, rdy0}, 0);
      sb.delete();
      busy = 0;
      last = 1;
      in_rsp = 0;
    end else begin
      g = (v[0] && v[1]) ? !last : v[1];
      er = (busy || v == 2'b00) ? 2'b00 : (g ? 2'b10 : 2'b01);
      chk("ready", {rdy1, rdy0}, er);
      if (rsp_valid) begin
        if (!in_rsp) begin
          chk("rsp_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk("rsp_id", rsp_id, cur.id);
            chk("rsp_result", rsp_result, cur.res);
            chk("rsp_zero", rsp_zero, cur.z);
            chk("rsp_lt", rsp_lt, cur.lt);
            chk("rsp_cycle", cyc, cur.due);
            got_res = rsp_result; got_id = rsp_id; got_z = rsp_zero; got_lt = rsp_lt;
            got_lat = cyc - cur.t;
            ids.push_back(rsp_id);
          end
          in_rsp = 1;
        end else
          chk("rsp_hold", {rsp_id, rsp_zero, rsp_lt, rsp_result}, {cur.id, cur.z, cur.lt, cur.res});
        chk("alu_in_rsp", {alu_control, alu_a, alu_b}, 0);
        if (rrdy) begin
          in_rsp = 0;
          busy = 0;
        end
      end else if (in_rsp) begin
        chk("rsp_dropped", rsp_valid, 1);
        in_rsp = 0;
        busy = 0;
      end else if (busy && sb.size() > 0) begin
        chk("alu_exec", {alu_control, alu_a, alu_b}, {sb[0].op, sb[0].a, sb[0].b});
        chk("exec_len", cyc < sb[0].due, 1);
      end else
        chk("alu_idle", {alu_control, alu_a, alu_b}, 0);
      if (er != 2'b00) begin
        e.id = g; e.op = op[g]; e.a = a[g]; e.b = b[g];
        e.res = ref_alu(e.op, e.a, e.b);
        e.z = e.res == 0;
        e.lt = $signed(e.a) < $signed(e.b);
        e.t = cyc;
        e.due = cyc + ref_lat(e.op) + 1;
        sb.push_back(e);
        busy = 1;
        last = g;
      end
    end
  end

  task automatic push(int p, logic [4:0] o, logic [31:0] x, logic [31:0] y);
    req_t r;
    r.op = o; r.a = x; r.b = y;
    if (p == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  function automatic logic [31:0] rnd_val();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
  endfunction

  task automatic push_rnd(int p);
    push(p, 5'($urandom_range(1, 15)), rnd_val(), rnd_val());
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(string nm);
    int i;
    for (i = 0; i < 300; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && v == 2'b00 && !busy) break;
      step();
    end
    chk(nm, i < 300, 1);
  endtask

  initial begin
    int i;
    rrdy = 1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    push(0, OP_ADD, 5, 7);
    drain("drain_add");
    chk("add_result", got_res, 12);
    chk("add_id", got_id, 0);
    chk("add_zero", got_z, 0);
    chk("add_lat", got_lat, 2);
    push(0, OP_MUL, 32'hFFFF_FFFD, 4);
    drain("drain_mul");
    chk("mul_result", got_res, 32'hFFFF_FFF4);
    chk("mul_lat", got_lat, MUL_RSP);
    push(1, OP_SLT, 32'hFFFF_FFFF, 1);
    drain("drain_slt");
    chk("slt_result", got_res, 1);
    chk("slt_lt", got_lt, 1);
    chk("slt_id", got_id, 1);
    rrdy = 0;
    push(0, OP_SUB, 9, 9);
    for (i = 0; i < 20 && !rsp_valid; i++) step();
    chk("sub_rsp_seen", rsp_valid, 1);
    push(1, OP_ADD, 1, 2);
    repeat (10) step();
    chk("sub_held_result", rsp_result, 0);
    chk("sub_held_zero", rsp_zero, 1);
    rrdy = 1;
    drain("drain_sub");
    push(0, OP_DIV, 100, 7);
    for (i = 0; i < 20 && alu_control == OP_NULL; i++) step();
    chk("div_exec_reached", alu_control, OP_DIV);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    repeat (6) step();
    chk("no_rsp_after_rst", {rsp_valid, in_rsp, busy}, 0);
    ids.delete();
    for (i = 0; i < 6; i++) begin
      push_rnd(0);
      push_rnd(1);
    end
    drain("drain_alt");
    chk("alt_count", ids.size(), 12);
    foreach (ids[k]) chk("alt_id", ids[k], k % 2);
    for (i = 0; i < 400; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0) push_rnd(0);
      if (q1.size() < 2 && $urandom_range(0, 2) == 0) push_rnd(1);
      rrdy = $urandom_range(0, 3) != 0;
      step();
    end
    rrdy = 1;
    drain("drain_rand");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
